// File: rtl/basic_down_counter_pkg.sv
// Shared types and constants for the basic down-counter and its prescaler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, maximum counter width, default parameter values.
package basic_down_counter_pkg;

  localparam int MAX_WIDTH = 32;

  localparam int                   DEFAULT_WIDTH        = 8;
  localparam logic [MAX_WIDTH-1:0] DEFAULT_PERIOD       = 32'd255;
  localparam int                   DEFAULT_PRESCALE_DIV = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/basic_down_counter_if.sv
// Control/status bundle between a controller and the down-counter.
// Latency: n/a (wires only).
// Backpressure: none; all strobes are single-cycle, sampled on the counter clock.
//
// master: drives clear, load, load_val, en, one_shot; observes cnt, tc, running, done.
// slave : the counter; samples the controls and drives the status outputs.
interface basic_down_counter_if #(
  parameter int Width = 8
);

  logic             clear;
  logic             load;
  logic [Width-1:0] load_val;
  logic             en;
  logic             one_shot;
  logic [Width-1:0] cnt;
  logic             tc;
  logic             running;
  logic             done;

  modport master (
    output clear, load, load_val, en, one_shot,
    input  cnt, tc, running, done
  );

  modport slave (
    input  clear, load, load_val, en, one_shot,
    output cnt, tc, running, done
  );

endinterface

// File: rtl/basic_prescaler.sv
// Enable-event divider: one tick per PrescaleDiv cycles with en_in high.
// Latency: tick is combinational, asserted during the PrescaleDiv-th enabled cycle.
// Backpressure: none; en_in gaps simply stall the count.
//
// Ports: clock, reset (async, active-low), sclr (sync clear to 0),
//        en_in (enable event), tick (divided event).
module basic_prescaler
  import basic_down_counter_pkg::*;
#(
  parameter int PrescaleDiv = DEFAULT_PRESCALE_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic sclr,
  input  logic en_in,
  output logic tick
);

  localparam int            CW   = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
  localparam logic [CW-1:0] LAST = CW'(PrescaleDiv - 1);

  logic [CW-1:0] pcnt;

  assign tick = en_in && (pcnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (sclr) begin
      pcnt <= '0;
    end else if (en_in) begin
      pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/basic_down_counter.sv
// Loadable down-counter with terminal-count pulse, continuous or one-shot mode.
// Latency: cnt/tc/running/done registered, valid one clock after the causing edge.
// Backpressure: none; count events arriving in IDLE or DONE are dropped.
//
// Ports: clock, reset (async, active-low), bus (basic_down_counter_if.slave):
//   clear, load, load_val, en, one_shot in; cnt, tc, running, done out.
// Optional: define BASIC_DOWN_COUNTER_PRESCALE_EN to divide en by PrescaleDiv.
module basic_down_counter
  import basic_down_counter_pkg::*;
#(
  parameter int                   Width       = DEFAULT_WIDTH,
  parameter logic [MAX_WIDTH-1:0] Period      = DEFAULT_PERIOD,
  parameter int                   PrescaleDiv = DEFAULT_PRESCALE_DIV
) (
  input  logic                 clock,
  input  logic                 reset,
  basic_down_counter_if.slave  bus
);

  // Elaboration-time parameter sanity checks.
  if (Width < 2 || Width > MAX_WIDTH) begin : g_bad_width
    $error("basic_down_counter: Width out of range 2..32");
  end
  if (Width < MAX_WIDTH && (Period >> Width) != 0) begin : g_bad_period
    $error("basic_down_counter: Period does not fit in Width bits");
  end
  if (PrescaleDiv < 1 || PrescaleDiv > 256) begin : g_bad_div
    $error("basic_down_counter: PrescaleDiv out of range 1..256");
  end

  localparam logic [Width-1:0] PERIOD_W = Period[Width-1:0];

  state_t           state;
  logic [Width-1:0] cnt_q;
  logic [Width-1:0] reload_reg;
  logic             mode_reg;
  logic             tc_q;
  logic             running_q;
  logic             done_q;
  logic             step;

`ifdef BASIC_DOWN_COUNTER_PRESCALE_EN
  // Only enabled clocks spent in RUN advance the prescaler, so a fresh
  // load always starts a full PrescaleDiv-long first event.
  logic pre_en;
  assign pre_en = bus.en && (state == RUN);

  basic_prescaler #(
    .PrescaleDiv (PrescaleDiv)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .sclr  (bus.clear || bus.load),
    .en_in (pre_en),
    .tick  (step)
  );
`else
  assign step = bus.en;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt_q      <= PERIOD_W;
      reload_reg <= PERIOD_W;
      mode_reg   <= 1'b0;
      tc_q       <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.clear) begin
        state     <= IDLE;
        cnt_q     <= reload_reg;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (bus.load) begin
        // Load restarts from any state and suppresses this cycle's count.
        state      <= RUN;
        cnt_q      <= bus.load_val;
        reload_reg <= bus.load_val;
        mode_reg   <= bus.one_shot;
        running_q  <= 1'b1;
        done_q     <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (step) begin
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
              end else begin
                // Zero has been consumed: pulse tc and reload or finish.
                tc_q <= 1'b1;
                if (mode_reg) begin
                  state     <= DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
                end else begin
                  cnt_q <= reload_reg;
                end
              end
            end
          end
          IDLE, DONE: ;
          default: begin
            // Unreachable encoding: recover to a safe idle state.
            state     <= IDLE;
            cnt_q     <= reload_reg;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule
